// File: rtl/arch_reg_status_file.sv
// Architectural register file with per-register rename status (busy + producing ROB tag).
// Commit writes retired values; rename marks registers pending; two combinational read ports.

module arch_reg_rd_port #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = 3,
  parameter int IDXW = 5
) (
  input  logic [IDXW-1:0]            rs_i,
  input  logic [NREG-1:0][XLEN-1:0]  regs_i,
  input  logic [NREG-1:0]            busy_i,
  input  logic [NREG-1:0][TAGW-1:0]  tags_i,
  input  logic                       commit_valid_i,
  input  logic [IDXW-1:0]            commit_idx_i,
  input  logic [TAGW-1:0]            commit_tag_i,
  input  logic [XLEN-1:0]            commit_data_i,
  output logic [XLEN-1:0]            value_o,
  output logic                       busy_o,
  output logic [TAGW-1:0]            tag_o
);

  always_comb begin
    value_o = '0;
    busy_o  = 1'b0;
    tag_o   = '0;
    if (rs_i != '0) begin
      if (!busy_i[rs_i]) begin
        value_o = regs_i[rs_i];
      end else if (commit_valid_i && commit_idx_i == rs_i &&
                   commit_tag_i == tags_i[rs_i]) begin
        // producer is retiring right now: forward its data instead of stalling a cycle
        value_o = commit_data_i;
      end else begin
        busy_o  = 1'b1;
        tag_o   = tags_i[rs_i];
        value_o = regs_i[rs_i];
      end
    end
  end

endmodule

module arch_reg_status_file #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int TAGW = 3,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit_valid_i,
  input  logic [IDXW-1:0]  commit_idx_i,
  input  logic [TAGW-1:0]  commit_tag_i,
  input  logic [XLEN-1:0]  commit_data_i,
  input  logic             rename_valid_i,
  input  logic [IDXW-1:0]  rename_rd_i,
  input  logic [TAGW-1:0]  rename_tag_i,
  input  logic             flush_i,
  input  logic [IDXW-1:0]  rs1_i,
  input  logic [IDXW-1:0]  rs2_i,
  output logic [XLEN-1:0]  rs1_value_o,
  output logic             rs1_busy_o,
  output logic [TAGW-1:0]  rs1_tag_o,
  output logic [XLEN-1:0]  rs2_value_o,
  output logic             rs2_busy_o,
  output logic [TAGW-1:0]  rs2_tag_o,
  output logic [31:0]      retired_cnt_o
);

  localparam int NRD = 2;

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           busy_q, busy_d;
  logic [NREG-1:0][TAGW-1:0] tag_q,  tag_d;
  logic [31:0]               cnt_q,  cnt_d;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    cnt_d  = cnt_q;
    if (commit_valid_i) begin
      cnt_d = cnt_q + 32'd1;
      if (commit_idx_i != '0) regs_d[commit_idx_i] = commit_data_i;
    end
    if (flush_i) begin
      busy_d = '0;
    end else begin
      // tag match guards against clearing a register that was renamed again after this producer
      if (commit_valid_i && tag_q[commit_idx_i] == commit_tag_i) busy_d[commit_idx_i] = 1'b0;
      if (rename_valid_i && rename_rd_i != '0) begin
        busy_d[rename_rd_i] = 1'b1;
        tag_d[rename_rd_i]  = rename_tag_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign retired_cnt_o = cnt_q;

  logic [NRD-1:0][IDXW-1:0] rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_value;
  logic [NRD-1:0]           rd_busy;
  logic [NRD-1:0][TAGW-1:0] rd_tag;

  assign rd_addr = {rs2_i, rs1_i};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    arch_reg_rd_port #(
      .XLEN(XLEN), .NREG(NREG), .TAGW(TAGW), .IDXW(IDXW)
    ) u_rd (
      .rs_i           (rd_addr[p]),
      .regs_i         (regs_q),
      .busy_i         (busy_q),
      .tags_i         (tag_q),
      .commit_valid_i (commit_valid_i),
      .commit_idx_i   (commit_idx_i),
      .commit_tag_i   (commit_tag_i),
      .commit_data_i  (commit_data_i),
      .value_o        (rd_value[p]),
      .busy_o         (rd_busy[p]),
      .tag_o          (rd_tag[p])
    );
  end

  assign rs1_value_o = rd_value[0];
  assign rs1_busy_o  = rd_busy[0];
  assign rs1_tag_o   = rd_tag[0];
  assign rs2_value_o = rd_value[1];
  assign rs2_busy_o  = rd_busy[1];
  assign rs2_tag_o   = rd_tag[1];

endmodule
